// File: rtl/fir_dec_pkg.sv
// Shared types and helpers for the FIR decimation buffer.
// Sample type, clog2 and the rounding constant used by the boxcar.
package fir_dec_pkg;

    localparam int DATA_W_DEF = 13;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Half an LSB of the shifted result: 2^(shift-1).
    function automatic int round_const(input int shift);
        return (shift > 0) ? (1 << (shift - 1)) : 0;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO with wrap-bit pointers.
// Head entry is always visible on rd_data; no empty bypass.
module sync_fifo_fwft
    import fir_dec_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    output logic                          full,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          empty,
    output logic [clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             rd_go;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign rd_go   = rd_en && !empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; the extra MSB tells full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_go) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fir_dec_buffer.sv
// Boxcar decimator for the low-pass FIR stream, feeding a
// show-ahead FIFO with a valid/ready output and sticky drop flag.
module fir_dec_buffer
    import fir_dec_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEC_LOG2   = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst_n,
    input  logic signed [DATA_W-1:0]          fir_out,
    input  logic                              fir_out_en,
    output logic signed [DATA_W-1:0]          dec_data,
    output logic                              dec_valid,
    input  logic                              dec_ready,
    output logic [clog2(FIFO_DEPTH+1)-1:0]    fifo_cnt,
    output logic                              dec_ovf,
    input  logic                              clr_ovf
);

    localparam int ACC_W = DATA_W + DEC_LOG2;
    localparam logic signed [ACC_W-1:0] RND =
        ACC_W'(round_const(DEC_LOG2));

    logic [DEC_LOG2-1:0]       phase;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   rounded;
    logic signed [DATA_W-1:0]  res_q;
    logic signed [DATA_W-1:0]  head;
    logic                      wr_pend;
    logic                      dump;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      rd_en;
    logic                      wr_en;
    logic                      drop;

    // M samples of DATA_W bits cannot overflow ACC_W, nor can
    // adding half an LSB of the shifted result.
    assign sum     = acc + $signed({{DEC_LOG2{fir_out[DATA_W-1]}},
                                    fir_out});
    assign rounded = sum + RND;
    assign dump    = fir_out_en && (&phase);

    // Phase and running sum advance only on qualified samples.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase <= '0;
            acc   <= '0;
        end else if (fir_out_en) begin
            phase <= phase + DEC_LOG2'(1);
            acc   <= dump ? '0 : sum;
        end
    end

    // Capture the rounded average and flag it for the FIFO.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            res_q   <= '0;
            wr_pend <= 1'b0;
        end else begin
            wr_pend <= dump;
            if (dump) begin
                res_q <= DATA_W'(rounded >>> DEC_LOG2);
            end
        end
    end

    // A read frees the slot on the same edge, so full+read still
    // accepts the pending result.
    assign rd_en = dec_ready && !fifo_empty;
    assign wr_en = wr_pend && (!fifo_full || rd_en);
    assign drop  = wr_pend && fifo_full && !rd_en;

    // Sticky drop flag; a new drop beats a clear on the same edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dec_ovf <= 1'b0;
        end else if (drop) begin
            dec_ovf <= 1'b1;
        end else if (clr_ovf) begin
            dec_ovf <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .wr_en   (wr_en),
        .wr_data (res_q),
        .full    (fifo_full),
        .rd_en   (rd_en),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    assign dec_valid = !fifo_empty;
    assign dec_data  = fifo_empty ? '0 : head;

endmodule

// File: tb/tb_fir_dec_buffer.sv
// Directed bench for fir_dec_buffer (M=4, depth 8).
// Expected averages go into a queue; a monitor pops on each transfer.
module tb_fir_dec_buffer;

    logic               sys_clk    = 1'b0;
    logic               sys_rst_n  = 1'b0;
    logic signed [12:0] fir_out    = '0;
    logic               fir_out_en = 1'b0;
    logic               dec_ready  = 1'b0;
    logic               clr_ovf    = 1'b0;
    logic signed [12:0] dec_data;
    logic               dec_valid;
    logic [3:0]         fifo_cnt;
    logic               dec_ovf;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int pushes = 0;
    int sb[$];

    fir_dec_buffer #(
        .DATA_W     (13),
        .DEC_LOG2   (2),
        .FIFO_DEPTH (8)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .fir_out    (fir_out),
        .fir_out_en (fir_out_en),
        .dec_data   (dec_data),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .fifo_cnt   (fifo_cnt),
        .dec_ovf    (dec_ovf),
        .clr_ovf    (clr_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int v);
        sb.push_back(v);
        pushes++;
    endtask

    task automatic put(input logic en, input int d);
        fir_out_en = en;
        fir_out    = 13'(d);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        fir_out_en = 1'b0;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        fir_out_en = 1'b0;
        while ((dec_valid || sb.size() != 0) && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        check(tag, 32'(n < 300), 1);
    endtask

    // Scoreboard: every accepted output must match the queue head.
    always @(negedge sys_clk) begin
        int exp_v;
        if (sys_rst_n && dec_valid && dec_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra: got %0d expected none",
                       dec_data);
            end
            if (sb.size() != 0) begin
                exp_v = sb.pop_front();
                pops++;
                assert (32'(dec_data) === exp_v) else begin
                    errors++;
                    $error("FAIL sb_data: got %0d expected %0d",
                           dec_data, exp_v);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_data", dec_data, 0);
        check("rst_valid", dec_valid, 0);
        check("rst_cnt", fifo_cnt, 0);
        check("rst_ovf", dec_ovf, 0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // Constant input and two-clock latency
        dec_ready = 1'b1;
        repeat (4) push(100);
        for (int i = 0; i < 16; i++) begin
            put(1'b1, 100);
            if (i == 3) begin
                @(negedge sys_clk);
                check("lat_e0", dec_valid, 0);
            end
            if (i == 4) begin
                @(negedge sys_clk);
                check("lat_e1", dec_valid, 1);
            end
        end
        drain("drain_const");

        // Rounding and extremes
        push(-1);
        push(2);
        push(-4096);
        push(4095);
        put(1'b1, -1); put(1'b1, -2); put(1'b1, -1); put(1'b1, -2);
        put(1'b1, 1);  put(1'b1, 2);  put(1'b1, 1);  put(1'b1, 2);
        for (int i = 0; i < 4; i++) put(1'b1, -4096);
        for (int i = 0; i < 4; i++) put(1'b1, 4095);
        drain("drain_round");

        // Gapped enable
        push(25);
        for (int i = 1; i <= 4; i++) begin
            put(1'b1, 10 * i);
            put(1'b0, 777);
            put(1'b0, 777);
        end
        drain("drain_gap");

        // Backpressure and overflow
        dec_ready = 1'b0;
        for (int k = 0; k < 8; k++) push(4 * k + 2);
        for (int i = 0; i < 40; i++) begin
            put(1'b1, i);
            if (i == 33) begin
                @(negedge sys_clk);
                check("ovf_cnt_full", fifo_cnt, 8);
                check("ovf_pre", dec_ovf, 0);
            end
        end
        idle(2);
        @(negedge sys_clk);
        check("ovf_cnt", fifo_cnt, 8);
        check("ovf_set", dec_ovf, 1);
        check("ovf_head", dec_data, 2);
        check("ovf_valid", dec_valid, 1);
        dec_ready = 1'b1;
        drain("drain_ovf");
        check("ovf_sticky", dec_ovf, 1);
        check("ovf_empty", fifo_cnt, 0);
        @(posedge sys_clk);
        #1;
        clr_ovf = 1'b1;
        @(posedge sys_clk);
        #1;
        clr_ovf = 1'b0;
        @(negedge sys_clk);
        check("ovf_clr", dec_ovf, 0);

        // Full with simultaneous read and write
        dec_ready = 1'b0;
        for (int k = 0; k < 8; k++) push(7);
        push(9);
        for (int i = 0; i < 32; i++) put(1'b1, 7);
        for (int i = 0; i < 4; i++) put(1'b1, 9);
        fir_out_en = 1'b0;
        dec_ready  = 1'b1;
        @(negedge sys_clk);
        check("rw_cnt_pre", fifo_cnt, 8);
        @(posedge sys_clk);
        #1;
        dec_ready = 1'b0;
        @(negedge sys_clk);
        check("rw_cnt", fifo_cnt, 8);
        check("rw_ovf", dec_ovf, 0);
        check("rw_head", dec_data, 7);
        dec_ready = 1'b1;
        drain("drain_rw");

        // Reset mid-operation discards FIFO and partial sum
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(1'b1, 5);
        idle(3);
        @(negedge sys_clk);
        check("mid_cnt", fifo_cnt, 1);
        put(1'b1, 999);
        put(1'b1, 999);
        fir_out_en = 1'b0;
        sys_rst_n  = 1'b0;
        @(negedge sys_clk);
        check("mid_rst_data", dec_data, 0);
        check("mid_rst_valid", dec_valid, 0);
        check("mid_rst_cnt", fifo_cnt, 0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        dec_ready = 1'b1;
        push(50);
        for (int i = 0; i < 4; i++) put(1'b1, 50);
        drain("drain_mid");
        idle(4);

        check("pops", pops, pushes);
        check("sb_left", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
